// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-locking arbiter for an async FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          wpush,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic               pick_found;
    logic               owner_last;
    logic               burst_end;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign owner_last = |(grant_q & req_last);
    assign burst_end  = wpush && (owner_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1)));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_LOCKED;
                    grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (burst_end) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    rr_ptr_d   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
                    beat_cnt_d = '0;
                end else if (wpush) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Everything below depends only on registered grant, so reset clears it at once.
    always_comb begin
        req_ready = '0;
        wpush     = 1'b0;
        wdata     = '0;
        busy      = (state_q == S_LOCKED);
        if (state_q == S_LOCKED) begin
            req_ready = grant_q & {NUM_REQ{~wfull}};
            wpush     = (|(grant_q & req_valid)) & ~wfull;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) wdata = wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed checks against a behavioural arbiter model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wfull = 1'b0;
    logic            wpush;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    grant;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .wpush(wpush),
        .wdata(wdata), .grant(grant), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 when idle), next-search start, beats taken this grant
    int m_owner, m_ptr, m_beats;
    int pushes_by [N];
    logic [N-1:0] acc_mask;
    int src_seq  [N];
    int src_left [N];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) pushes_by[i] = 0;
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic [N-1:0]  e_grant, e_ready;
        logic          e_push;
        logic [DW-1:0] e_data;
        #1;
        e_grant = '0; e_ready = '0; e_push = 1'b0; e_data = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = !wfull;
            e_push = req_valid[m_owner] && !wfull;
            e_data = req_data[m_owner*DW +: DW];
        end
        check_eq("grant", grant, e_grant);
        check_eq("busy", busy, m_owner >= 0);
        check_eq("req_ready", req_ready, e_ready);
        check_eq("wpush", wpush, e_push);
        check_eq("wdata", wdata, e_data);
        acc_mask = '0;
        if (e_push) acc_mask[m_owner] = 1'b1;
        for (int i = 0; i < N; i++) if (wpush && grant == (N'(1) << i)) pushes_by[i]++;
        @(posedge wclk);
        if (!wrst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                end
            end
        end else if (e_push) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_beats = 0;
            end
        end
        @(negedge wclk);
    endtask

    task automatic apply_reset();
        wrst_n = 1'b0;
        req_valid = '0; req_last = '0; wfull = 1'b0;
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // Sources advance only on beats the model says were accepted; data is stable until then.
    task automatic drive_random(input int p_valid, input int p_full);
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                src_seq[i]++;
                if (src_left[i] == 1) src_left[i] = $urandom_range(1, 20);
                else src_left[i]--;
            end
            req_valid[i] = ($urandom_range(0, 99) < p_valid);
            req_last[i]  = (src_left[i] == 1);
            req_data[i*DW +: DW] = {8'(i), 24'(src_seq[i])};
        end
        wfull = ($urandom_range(0, 99) < p_full);
    endtask

    initial begin
        acc_mask = '0;
        for (int i = 0; i < N; i++) begin
            src_seq[i]  = 0;
            src_left[i] = $urandom_range(1, 20);
        end
        clear_counts();
        apply_reset();
        cycle();

        // Single requester 2, three-beat burst
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'hA0;
        cycle();
        check_eq("single_grant", grant, 4'b0100);
        clear_counts();
        for (int b = 0; b < 3; b++) begin
            req_data[2*DW +: DW] = 32'hA0 + 32'(b);
            req_last = (b == 2) ? 4'b0100 : 4'b0000;
            #1;
            check_eq("single_wdata", wdata, 32'hA0 + 32'(b));
            check_eq("single_wpush", wpush, 1'b1);
            cycle();
        end
        req_valid = '0; req_last = '0;
        check_eq("single_release", grant, 4'b0000);
        check_eq("single_pushes", pushes_by[2], 3);
        req_valid = 4'b1001;
        cycle();
        check_eq("rr_after_single", grant, 4'b1000);
        req_valid = '0;
        for (int c = 0; c < 20; c++) cycle();

        // Round robin with one-beat bursts
        apply_reset();
        clear_counts();
        req_valid = 4'b1111; req_last = 4'b1111;
        for (int c = 0; c < 8; c++) cycle();
        for (int i = 0; i < N; i++) check_eq("rr_one_each", pushes_by[i], 1);

        // Forced release after MAX_BEATS
        apply_reset();
        clear_counts();
        req_valid = 4'b0011; req_last = 4'b0000;
        for (int c = 0; c < 17; c++) cycle();
        check_eq("forced_bubble", grant, 4'b0000);
        cycle();
        check_eq("forced_next", grant, 4'b0010);
        check_eq("forced_pushes", pushes_by[0], MB);
        req_valid = 4'b0000;
        for (int c = 0; c < 20; c++) cycle();

        // Asynchronous reset mid-burst
        apply_reset();
        req_valid = 4'b0100; req_last = 4'b0000;
        for (int c = 0; c < 3; c++) cycle();
        #2;
        wrst_n = 1'b0;
        #1;
        check_eq("arst_wpush", wpush, 1'b0);
        check_eq("arst_ready", req_ready, 4'b0000);
        check_eq("arst_grant", grant, 4'b0000);
        check_eq("arst_busy", busy, 1'b0);
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        req_valid = 4'b1010;
        cycle();
        check_eq("arst_restart", grant, 4'b0010);
        req_valid = '0;
        for (int c = 0; c < 20; c++) cycle();

        // Randomized phases: heavy load, back-pressure, saturation, sparse
        acc_mask = '0;
        for (int c = 0; c < 500; c++) begin drive_random(90, 0);   cycle(); end
        for (int c = 0; c < 500; c++) begin drive_random(60, 30);  cycle(); end
        for (int c = 0; c < 500; c++) begin drive_random(100, 10); cycle(); end
        for (int c = 0; c < 500; c++) begin drive_random(30, 50);  cycle(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
